// File: rtl/pomo_key_sched.sv
// pomo_key_sched: debounces the front-panel keys, serialises LOAD/SS/MODE requests by priority
// and owns the BCD work-time register set_t. Define KEY_DOWN_EN to add a DOWN key for set_t.

module pomo_key_rep #(
    parameter int REPEAT_DELAY  = 50,
    parameter int REPEAT_PERIOD = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic block,
    input  logic level,
    input  logic press,
    output logic step
);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCW  = $clog2(RMAX + 1);
    localparam logic [RCW-1:0] DELAY_LAST  = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] PERIOD_LAST = RCW'(REPEAT_PERIOD - 1);

    logic           armed;
    logic           repeating;
    logic [RCW-1:0] cnt;
    logic           tick;

    // Only a press seen while enabled arms the timer, so re-entry with the key held stays silent.
    assign tick = armed && level && (cnt == (repeating ? PERIOD_LAST : DELAY_LAST));
    assign step = en && !block && (press || tick);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed     <= 1'b0;
            repeating <= 1'b0;
            cnt       <= '0;
        end else if (!en || block || !level) begin
            armed     <= 1'b0;
            repeating <= 1'b0;
            cnt       <= '0;
        end else if (press) begin
            armed     <= 1'b1;
            repeating <= 1'b0;
            cnt       <= '0;
        end else if (armed) begin
            if (tick) begin
                cnt       <= '0;
                repeating <= 1'b1;
            end else begin
                cnt <= cnt + RCW'(1);
            end
        end
    end
endmodule

module pomo_key_sched #(
    parameter int         DEB_CYCLES    = 20,
    parameter int         REPEAT_DELAY  = 50,
    parameter int         REPEAT_PERIOD = 10,
    parameter logic [7:0] SET_MIN       = 8'h01,
    parameter logic [7:0] SET_MAX       = 8'h59,
    parameter logic [7:0] SET_DEFAULT   = 8'h25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_load_raw,
    input  logic       key_ss_raw,
    input  logic       key_mode_raw,
    input  logic       key_up_raw,
`ifdef KEY_DOWN_EN
    input  logic       key_down_raw,
`endif
    input  logic [2:0] cstate,
    output logic       key_load,
    output logic       key_ss,
    output logic       key_mode,
    output logic       key_drop,
    output logic [7:0] set_t
);
`ifdef KEY_DOWN_EN
    localparam int NK = 5;
`else
    localparam int NK = 4;
`endif
    localparam int K_LOAD = 0;
    localparam int K_SS   = 1;
    localparam int K_MODE = 2;
    localparam int K_UP   = 3;
    localparam int DCW = $clog2(DEB_CYCLES);
    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 1);
    localparam logic [2:0] SET_TIME = 3'b110;

    logic [NK-1:0]           raw;
    logic [NK-1:0]           sync1;
    logic [NK-1:0]           sync2;
    logic [NK-1:0]           level;
    logic [NK-1:0]           press;
    logic [NK-1:0][DCW-1:0]  deb_cnt;
    logic [2:0]              pend;
    logic [2:0]              req;
    logic [2:0]              grant;
    logic                    in_set;
    logic                    conflict;
    logic                    up_step;
    logic [7:0]              set_next;

`ifdef KEY_DOWN_EN
    localparam int K_DOWN = 4;
    logic dn_step;
    assign raw      = {key_down_raw, key_up_raw, key_mode_raw, key_ss_raw, key_load_raw};
    assign conflict = level[K_UP] & level[K_DOWN];
`else
    assign raw      = {key_up_raw, key_mode_raw, key_ss_raw, key_load_raw};
    assign conflict = 1'b0;
`endif

    // press is registered on the same edge the debounced level rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            press   <= '0;
            deb_cnt <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= '0;
            for (int k = 0; k < NK; k++) begin
                if (sync2[k] == level[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == DEB_LAST) begin
                    deb_cnt[k] <= '0;
                    level[k]   <= sync2[k];
                    press[k]   <= sync2[k];
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + DCW'(1);
                end
            end
        end
    end

    // A fresh press competes in the same cycle it arrives, saving one cycle of latency.
    assign req = pend | press[K_MODE:K_LOAD];

    always_comb begin
        grant = 3'b000;
        if (req[K_LOAD])      grant[K_LOAD] = 1'b1;
        else if (req[K_SS])   grant[K_SS]   = 1'b1;
        else if (req[K_MODE]) grant[K_MODE] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            key_load <= 1'b0;
            key_ss   <= 1'b0;
            key_mode <= 1'b0;
            key_drop <= 1'b0;
        end else begin
            pend     <= req & ~grant;
            key_load <= grant[K_LOAD];
            key_ss   <= grant[K_SS];
            key_mode <= grant[K_MODE];
            key_drop <= |(pend & press[K_MODE:K_LOAD]);
        end
    end

    assign in_set = (cstate == SET_TIME);

    pomo_key_rep #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_up_rep (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_set),
        .block (conflict),
        .level (level[K_UP]),
        .press (press[K_UP]),
        .step  (up_step)
    );

`ifdef KEY_DOWN_EN
    pomo_key_rep #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_dn_rep (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_set),
        .block (conflict),
        .level (level[K_DOWN]),
        .press (press[K_DOWN]),
        .step  (dn_step)
    );

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v == SET_MIN)      return SET_MAX;
        if (v[3:0] == 4'd0)    return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction
`endif

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == SET_MAX)      return SET_MIN;
        if (v[3:0] == 4'd9)    return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_comb begin
        set_next = set_t;
        if (up_step) set_next = bcd_inc(set_t);
`ifdef KEY_DOWN_EN
        else if (dn_step) set_next = bcd_dec(set_t);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) set_t <= SET_DEFAULT;
        else        set_t <= set_next;
    end
endmodule
